key_debounce: RTL and testbench

Debounces one raw mechanical push-button input and produces a clean, glitch-free level for the falling-edge detector that sits directly downstream. The key is active-low and idles high. The block provides:

- a two-flop synchronizer, then
- a four-state filter FSM that only accepts a new level after it has been held stable for a programmable number of cycles.

`o_key_stable` feeds the edge detector's `i_data_in`. Its reset/idle value of 1 matches that detector's reset state, so no spurious edge is generated out of reset.

---
 rtl/key_debounce.sv | 115 +++++++++++
 tb/tb_key_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state filter FSM.
// The output level only changes after DEBOUNCE_CYCLES consecutive samples at the new level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_key_stable,
  output logic o_filtering
);

  typedef enum logic [1:0] {
    IDLE_HIGH   = 2'b00,
    FILTER_LOW  = 2'b01,
    HOLD_LOW    = 2'b10,
    FILTER_HIGH = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_p0;
  logic             key_p1;
  state_t           state_p2;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_p2;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_p2;
  logic             stable_nxt;

  // Stage p0/p1: synchronizer, idles at the released level so reset never looks like a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= i_key;
      key_p1 <= key_p0;
    end
  end

  // Stage p2: filter state, stability counter and debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p2  <= IDLE_HIGH;
      cnt_p2    <= '0;
      stable_p2 <= 1'b1;
    end else begin
      state_p2  <= state_nxt;
      cnt_p2    <= cnt_nxt;
      stable_p2 <= stable_nxt;
    end
  end

  always_comb begin
    state_nxt  = IDLE_HIGH;
    cnt_nxt    = '0;
    stable_nxt = 1'b1;
    case (state_p2)
      IDLE_HIGH: begin
        stable_nxt = 1'b1;
        if (!key_p1) begin
          state_nxt = FILTER_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE_HIGH;
        end
      end
      FILTER_LOW: begin
        stable_nxt = 1'b1;
        if (key_p1) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt_p2 == CNT_LAST) begin
          state_nxt  = HOLD_LOW;
          stable_nxt = 1'b0;
        end else begin
          state_nxt = FILTER_LOW;
          cnt_nxt   = cnt_p2 + CNT_ONE;
        end
      end
      HOLD_LOW: begin
        stable_nxt = 1'b0;
        if (key_p1) begin
          state_nxt = FILTER_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = HOLD_LOW;
        end
      end
      FILTER_HIGH: begin
        stable_nxt = 1'b0;
        if (!key_p1) begin
          state_nxt = HOLD_LOW;
        end else if (cnt_p2 == CNT_LAST) begin
          state_nxt  = IDLE_HIGH;
          stable_nxt = 1'b1;
        end else begin
          state_nxt = FILTER_HIGH;
          cnt_nxt   = cnt_p2 + CNT_ONE;
        end
      end
      default: begin
        state_nxt  = IDLE_HIGH;
        cnt_nxt    = '0;
        stable_nxt = 1'b1;
      end
    endcase
  end

  assign o_key_stable = stable_p2;
  assign o_filtering  = (state_p2 == FILTER_LOW) || (state_p2 == FILTER_HIGH);

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bounce, checked against a
// run-length model of the acceptance rule.
module tb_key_debounce;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_key = 1'b1;
  logic o_key_stable;
  logic o_filtering;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: s1 delay line plus count of consecutive samples at the opposite level
  logic m_s0, m_s1, m_stable;
  int   m_run;

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .i_key(i_key),
    .o_key_stable(o_key_stable),
    .o_filtering(o_filtering)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s0 = 1'b1; m_s1 = 1'b1; m_stable = 1'b1; m_run = 0;
  endtask

  task automatic model_edge();
    logic seen;
    seen = m_s1;
    m_s1 = m_s0;
    m_s0 = i_key;
    if (seen != m_stable) begin
      m_run++;
      if (m_run == D) begin
        m_stable = seen;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic key);
    i_key = key;
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic settle_high();
    for (int i = 0; i < D + 4; i++) step(1'b1);
  endtask

  task automatic test_reset();
    model_reset();
    i_key = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (o_key_stable !== 1'b1 || o_filtering !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got stable=%b filt=%b, exp stable=1 filt=0", o_key_stable, o_filtering);
    end
    rst = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      step(1'b0);
      vectors++;
      if (o_key_stable !== (j < 5) || o_filtering !== (j >= 2 && j <= 4)) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got stable=%b filt=%b, exp stable=%b filt=%b",
                 j, o_key_stable, o_filtering, (j < 5), (j >= 2 && j <= 4));
      end
    end
    settle_high();
  endtask

  task automatic test_clean_press();
    int downs;
    logic prev;
    downs = 0;
    prev = o_key_stable;
    for (int j = 0; j <= 7; j++) begin
      step(1'b0);
      if (prev && !o_key_stable) downs++;
      prev = o_key_stable;
      vectors++;
      if (o_key_stable !== (j < 5) || o_filtering !== (j >= 2 && j <= 4)) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got stable=%b filt=%b, exp stable=%b filt=%b",
                 j, o_key_stable, o_filtering, (j < 5), (j >= 2 && j <= 4));
      end
    end
    vectors++;
    if (downs !== 1) begin
      miscompares++;
      $display("FAIL clean_press_edges: got %0d falling edges, exp 1", downs);
    end
    settle_high();
  endtask

  task automatic test_bounce();
    logic [14:0] pat;
    logic saw_filt;
    pat = 15'b111111110001000;  // applied LSB first: 0,0,0,1,0,0,0 then high
    saw_filt = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step(pat[j]);
      saw_filt |= o_filtering;
      vectors++;
      if (o_key_stable !== 1'b1 || o_key_stable !== m_stable || o_filtering !== (m_run != 0)) begin
        miscompares++;
        $display("FAIL bounce step %0d: got stable=%b filt=%b, exp stable=1 filt=%b",
                 j, o_key_stable, o_filtering, (m_run != 0));
      end
    end
    vectors++;
    if (!saw_filt || o_filtering !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_filt_pulse: got seen=%b final=%b, exp seen=1 final=0", saw_filt, o_filtering);
    end
  endtask

  task automatic test_boundary();
    for (int len = D - 1; len <= D; len++) begin
      for (int j = 0; j <= 12; j++) begin
        logic exp_s;
        step((j < len) ? 1'b0 : 1'b1);
        exp_s = (len == D) ? !(j >= 5 && j <= 8) : 1'b1;
        vectors++;
        if (o_key_stable !== exp_s || o_key_stable !== m_stable || o_filtering !== (m_run != 0)) begin
          miscompares++;
          $display("FAIL boundary len %0d edge %0d: got stable=%b filt=%b, exp stable=%b filt=%b",
                   len, j, o_key_stable, o_filtering, exp_s, (m_run != 0));
        end
      end
      settle_high();
    end
  endtask

  task automatic test_release_bounce();
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int k = 0; k < 10; k++) begin
      step((k % 2) == 0);
      vectors++;
      if (o_key_stable !== 1'b0 || o_filtering !== (m_run != 0)) begin
        miscompares++;
        $display("FAIL release_toggle %0d: got stable=%b filt=%b, exp stable=0 filt=%b",
                 k, o_key_stable, o_filtering, (m_run != 0));
      end
    end
    for (int j = 0; j <= 7; j++) begin
      step(1'b1);
      vectors++;
      if (o_key_stable !== (j >= 5) || o_filtering !== (m_run != 0)) begin
        miscompares++;
        $display("FAIL release_hold edge %0d: got stable=%b filt=%b, exp stable=%b filt=%b",
                 j, o_key_stable, o_filtering, (j >= 5), (m_run != 0));
      end
    end
    settle_high();
  endtask

  task automatic test_reset_mid_filter();
    for (int j = 0; j < 4; j++) step(1'b0);
    vectors++;
    if (o_filtering !== 1'b1 || o_key_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_filter_setup: got stable=%b filt=%b, exp stable=1 filt=1", o_key_stable, o_filtering);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (o_key_stable !== 1'b1 || o_filtering !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_filter_async_reset: got stable=%b filt=%b, exp stable=1 filt=0", o_key_stable, o_filtering);
    end
    i_key = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step(1'b1);
      vectors++;
      if (o_key_stable !== 1'b1 || o_filtering !== 1'b0 || m_stable !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_filter_after edge %0d: got stable=%b filt=%b, exp stable=1 filt=0",
                 j, o_key_stable, o_filtering);
      end
    end
  endtask

  task automatic test_random();
    logic lvl;
    lvl = 1'b0;
    for (int r = 0; r < 60; r++) begin
      int len;
      len = $urandom_range(1, 2 * D);
      for (int j = 0; j < len; j++) begin
        step(lvl);
        vectors++;
        if (o_key_stable !== m_stable || o_filtering !== (m_run != 0)) begin
          miscompares++;
          $display("FAIL random run %0d step %0d: got stable=%b filt=%b, exp stable=%b filt=%b",
                   r, j, o_key_stable, o_filtering, m_stable, (m_run != 0));
        end
      end
      lvl = ~lvl;
    end
    settle_high();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_boundary();
    test_release_bounce();
    test_reset_mid_filter();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
